// File: rtl/if_prefetch_queue_pkg.sv
// Shared constants and FSM state type for the instruction-fetch prefetch queue.
package if_prefetch_queue_pkg;

    localparam int          INST_BYTES           = 4;
    localparam int          IFQ_DEFAULT_DEPTH    = 4;
    localparam logic [31:0] IFQ_DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        IFQ_FETCH = 1'b0,
        IFQ_FULL  = 1'b1
    } ifq_state_t;

endpackage

// File: rtl/if_prefetch_queue_ram.sv
// Payload storage for the prefetch queue: one synchronous write port, one
// asynchronous read port, no reset on the contents.
module if_prefetch_queue_ram #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: drives the instruction bus and buffers fetched
// {pc, inst} pairs. Optional zero-latency bypass when IFQ_BYPASS_EN is defined.
module if_prefetch_queue
    import if_prefetch_queue_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = IFQ_DEFAULT_DEPTH,
    parameter logic [XLEN-1:0] RESET_PC = IFQ_DEFAULT_RESET_PC
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [XLEN-1:0]            IAD,
    output logic                       IREQ,
    input  logic [XLEN-1:0]            IDT,
    input  logic                       ACKI_n,
    input  logic                       redirect,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_inst,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    ifq_state_t        state;
    logic [XLEN-1:0]   fetch_pc;
    logic              ireq;
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     occ;

    logic              push;
    logic              pop;
    logic              bypass;
    logic              wr_en;
    logic              q_valid;
    logic [2*XLEN-1:0] rd_entry;

    assign IAD     = fetch_pc;
    assign IREQ    = ireq;
    assign count   = occ;
    assign q_valid = (occ != '0);

    // A redirect discards any ack and any pop seen in the same cycle.
    assign push = ireq && (state == IFQ_FETCH) && !ACKI_n && !redirect;
    assign pop  = q_valid && out_ready && !redirect;

`ifdef IFQ_BYPASS_EN
    assign bypass = push && !q_valid && out_ready;
`else
    assign bypass = 1'b0;
`endif

    assign wr_en = push && !bypass;

    if_prefetch_queue_ram #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (tail),
        .wdata ({fetch_pc, IDT}),
        .raddr (head),
        .rdata (rd_entry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IFQ_FETCH;
            ireq     <= 1'b0;
            fetch_pc <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
        end else if (redirect) begin
            state    <= IFQ_FETCH;
            ireq     <= 1'b1;
            fetch_pc <= redirect_pc & ~XLEN'(INST_BYTES - 1);
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + XLEN'(INST_BYTES);
            end
            if (wr_en) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            if (wr_en && !pop) begin
                occ <= occ + CW'(1);
            end else if (pop && !wr_en) begin
                occ <= occ - CW'(1);
            end
            // IREQ is registered alongside the state so it drops the cycle the queue fills.
            case (state)
                IFQ_FETCH: begin
                    if (wr_en && !pop && (occ == CW'(DEPTH - 1))) begin
                        state <= IFQ_FULL;
                        ireq  <= 1'b0;
                    end else begin
                        ireq  <= 1'b1;
                    end
                end
                IFQ_FULL: begin
                    if (pop) begin
                        state <= IFQ_FETCH;
                        ireq  <= 1'b1;
                    end
                end
                default: begin
                    state <= IFQ_FETCH;
                    ireq  <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        out_valid = q_valid;
        out_pc    = q_valid ? rd_entry[2*XLEN-1:XLEN] : '0;
        out_inst  = q_valid ? rd_entry[XLEN-1:0] : '0;
`ifdef IFQ_BYPASS_EN
        if (bypass) begin
            out_valid = 1'b1;
            out_pc    = fetch_pc;
            out_inst  = IDT;
        end
`endif
    end

endmodule
